// File: rtl/vendo_multi.sv
// vendo_multi: vending-machine controller for NUM_ITEMS products with per-item prices.
// Accumulates 1- and 5-unit coin credit and dispenses the selected item. Change or a
// cancelled credit is returned as one change pulse per unit.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_sel     one-hot item select, sampled in IDLE only
//   i_p_1     1-unit coin strobe
//   i_p_5     5-unit coin strobe
//   i_cancel  abort purchase and refund credit (COLLECT only)
//   o_disp    one-hot dispense pulse, 1 cycle
//   o_change  change pulse, one unit per high cycle
//   o_busy    high in every state except IDLE
//   o_credit  accumulated credit
module vendo_multi #(
  parameter int                             NUM_ITEMS = 2,
  parameter int                             PRICE_W   = 5,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]   PRICES    = {5'd4, 5'd3},
  parameter int                             CREDIT_W  = PRICE_W + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_ITEMS-1:0] i_sel,
  input  logic                 i_p_1,
  input  logic                 i_p_5,
  input  logic                 i_cancel,
  output logic [NUM_ITEMS-1:0] o_disp,
  output logic                 o_change,
  output logic                 o_busy,
  output logic [CREDIT_W-1:0]  o_credit
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_item;
  logic [CREDIT_W-1:0]  r_credit;
  logic [CREDIT_W-1:0]  r_cnt;      // change units still owed
  logic [NUM_ITEMS-1:0] r_disp;
  logic                 r_change;
  logic                 r_busy;

  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_sel_onehot;
  logic [PRICE_W-1:0]   w_sel_price;
  logic [PRICE_W-1:0]   w_item_price;
  logic [CREDIT_W-1:0]  w_price_c;
  logic [CREDIT_W-1:0]  w_nxt;

  assign w_sel_onehot = $onehot(i_sel);

  // Encode the select and look up prices for both the incoming select and the latched item.
  always_comb begin
    w_sel_idx    = '0;
    w_sel_price  = '0;
    w_item_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_sel[i]) w_sel_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (w_sel_idx == IDX_W'(i)) w_sel_price  = PRICES[i*PRICE_W +: PRICE_W];
      if (r_item    == IDX_W'(i)) w_item_price = PRICES[i*PRICE_W +: PRICE_W];
    end
  end

  assign w_price_c = CREDIT_W'(w_item_price);
  // credit < price before the add, so this never exceeds price + 5
  assign w_nxt     = r_credit + CREDIT_W'(i_p_1) + (i_p_5 ? CREDIT_W'(5) : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_item   <= '0;
      r_credit <= '0;
      r_cnt    <= '0;
      r_disp   <= '0;
      r_change <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_disp   <= '0;
      r_change <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_onehot) begin
            r_item <= w_sel_idx;
            r_busy <= 1'b1;
            if (w_sel_price == '0) begin
              // free item: dispense immediately, nothing owed
              r_state <= S_VEND;
              r_disp  <= NUM_ITEMS'(1) << w_sel_idx;
              r_cnt   <= '0;
            end else begin
              r_state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (i_cancel) begin
            // cancel wins over a completing coin; the coin is refunded too
            r_credit <= '0;
            if (w_nxt == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt    <= w_nxt;
              r_change <= 1'b1;
              r_state  <= S_CHANGE;
            end
          end else if (w_nxt >= w_price_c) begin
            r_credit <= '0;
            r_cnt    <= w_nxt - w_price_c;
            r_disp   <= NUM_ITEMS'(1) << r_item;
            r_state  <= S_VEND;
          end else begin
            r_credit <= w_nxt;
          end
        end
        S_VEND: begin
          if (r_cnt != '0) begin
            r_change <= 1'b1;
            r_state  <= S_CHANGE;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CHANGE: begin
          // r_cnt counts the pulse currently on the output; leave after the last one
          r_cnt <= r_cnt - CREDIT_W'(1);
          if (r_cnt == CREDIT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_change <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_disp   = r_disp;
  assign o_change = r_change;
  assign o_busy   = r_busy;
  assign o_credit = r_credit;

endmodule

// File: tb/tb_vendo_multi.sv
// tb_vendo_multi: directed and randomized stimulus for vendo_multi, checked every cycle
// against a transaction-level model that queues the expected output cycles of a purchase.
module tb_vendo_multi;

  localparam int N  = 2;
  localparam int PW = 5;
  localparam int CW = PW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sel;
  logic          p1, p5, cancel;
  logic [N-1:0]  disp;
  logic          chg, busy;
  logic [CW-1:0] credit;

  always #5 clk = ~clk;

  vendo_multi #(.NUM_ITEMS(N), .PRICE_W(PW), .PRICES({5'd4, 5'd3}), .CREDIT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_p_1(p1), .i_p_5(p5), .i_cancel(cancel),
    .o_disp(disp), .o_change(chg), .o_busy(busy), .o_credit(credit)
  );

  typedef struct {
    logic [N-1:0]  disp;
    logic          chg;
    logic          busy;
    logic [CW-1:0] credit;
  } out_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   price [N] = '{3, 4};
  out_t q[$];
  int   m_credit = 0;
  int   m_item   = 0;
  bit   m_coll   = 0;
  int   cyc_no   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
    end
  endtask

  function automatic out_t mk(input int d, input bit c, input bit b, input int cr);
    out_t o;
    o.disp = N'(d); o.chg = c; o.busy = b; o.credit = CW'(cr);
    return o;
  endfunction

  // Expected outputs after the current edge, given the inputs sampled at it.
  task automatic model(output out_t e);
    int nxt;
    if (rst) begin
      q.delete(); m_coll = 0; m_credit = 0;
      e = mk(0, 0, 0, 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();                       // machine busy: inputs ignored
    end else if (m_coll) begin
      nxt = m_credit + (p1 ? 1 : 0) + (p5 ? 5 : 0);
      if (cancel) begin
        m_coll = 0; m_credit = 0;
        if (nxt == 0) e = mk(0, 0, 0, 0);
        else begin
          e = mk(0, 1, 1, 0);
          for (int k = 1; k < nxt; k++) q.push_back(mk(0, 1, 1, 0));
          q.push_back(mk(0, 0, 0, 0));
        end
      end else if (nxt >= price[m_item]) begin
        m_coll = 0; m_credit = 0;
        e = mk(1 << m_item, 0, 1, 0);
        for (int k = 0; k < nxt - price[m_item]; k++) q.push_back(mk(0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 0));
      end else begin
        m_credit = nxt;
        e = mk(0, 0, 1, nxt);
      end
    end else if (sel == 2'b01 || sel == 2'b10) begin
      m_item = (sel == 2'b10) ? 1 : 0;
      if (price[m_item] == 0) begin
        e = mk(1 << m_item, 0, 1, 0);
        q.push_back(mk(0, 0, 0, 0));
      end else begin
        m_coll = 1;
        e = mk(0, 0, 1, 0);
      end
    end else begin
      e = mk(0, 0, 0, 0);
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] s, input logic a, input logic b,
                     input logic c);
    out_t e;
    rst = r; sel = s; p1 = a; p5 = b; cancel = c;
    @(posedge clk);
    model(e);
    #1;
    cyc_no++;
    chk("disp",   32'(disp),   32'(e.disp));
    chk("change", 32'(chg),    32'(e.chg));
    chk("busy",   32'(busy),   32'(e.busy));
    chk("credit", 32'(credit), 32'(e.credit));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    rst = 1; sel = '0; p1 = 0; p5 = 0; cancel = 0;
    // reset with random inputs, then quiet idle
    for (int i = 0; i < 4; i++)
      cyc(1, N'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    idle(3);
    // price 3, three 1-unit coins, exact payment
    cyc(0, 2'b01, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    idle(3);
    // price 4, one 5-unit coin, one unit of change
    cyc(0, 2'b10, 0, 0, 0); cyc(0, 0, 0, 1, 0); idle(4);
    // price 3, 1 then 1+5 together -> 4 change
    cyc(0, 2'b01, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0); idle(7);
    // cancel after 2 units
    cyc(0, 2'b10, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1); idle(4);
    // cancel at zero credit
    cyc(0, 2'b10, 0, 0, 0); cyc(0, 0, 0, 0, 1); idle(2);
    // cancel + 5-unit coin at credit 2 -> 7 pulses
    cyc(0, 2'b10, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 1); idle(9);
    // multi-hot select ignored
    cyc(0, 2'b11, 1, 1, 1); cyc(0, 2'b11, 0, 1, 0); idle(2);
    // coin during change ignored
    cyc(0, 2'b01, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 2'b10, 0, 1, 0); cyc(0, 0, 1, 1, 1); idle(5);
    // reset on the 2nd of 4 change pulses
    cyc(0, 2'b01, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); idle(5);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] s;
      case ($urandom_range(5))
        0, 2:    s = 2'b01;
        1, 3:    s = 2'b10;
        4:       s = 2'b00;
        default: s = 2'b11;
      endcase
      cyc(($urandom_range(99) == 0), s, ($urandom_range(2) == 0), ($urandom_range(5) == 0),
          ($urandom_range(15) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
